// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction prefetch front end.
package fetch_pkg;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned INSTR_W = 19;

    // One buffered instruction together with the address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RUN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  fetch_entry_t  i_push_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output fetch_entry_t  o_head,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // Pushing into a full FIFO is only allowed when the head leaves the same cycle
    assign w_push  = i_push & (~w_full | w_pop);

    // Entry storage; reset clears it so an idle head reads as zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (w_push && !i_flush) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher: issues fetches under a credit limit,
// buffers tagged responses and discards responses made stale by redirects.
module instr_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imem_req_valid,
    output logic [PC_W-1:0]    o_imem_req_addr,
    input  logic               i_imem_req_ready,
    input  logic               i_imem_resp_valid,
    input  logic [INSTR_W-1:0] i_imem_resp_instr,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    input  logic               i_instr_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Two spare bits so the three-way credit sum cannot wrap
    localparam int unsigned SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [SW-1:0]   w_outstanding;
    logic            w_fire;
    logic            w_resp_any;
    logic            w_resp_drop;
    logic            w_resp_keep;
    logic            w_deq;

    // Every outstanding request owns a FIFO slot, so responses can never overflow
    assign w_outstanding    = SW'(w_count) + SW'(r_inflight) + SW'(r_drop);
    assign o_imem_req_valid = (r_state == S_RUN) & ~i_redirect & (w_outstanding < DEPTH_SUM);
    assign o_imem_req_addr  = r_fetch_pc;
    assign w_fire           = o_imem_req_valid & i_imem_req_ready;

    // Responses with nothing outstanding are protocol errors and are ignored
    assign w_resp_any  = i_imem_resp_valid & ((r_inflight != '0) | (r_drop != '0));
    assign w_resp_drop = i_imem_resp_valid & (r_drop != '0);
    assign w_resp_keep = i_imem_resp_valid & (r_drop == '0) & (r_inflight != '0) & ~i_redirect;

    assign w_deq       = ~w_empty & i_instr_ready & ~i_redirect;
    assign w_push_data = '{instr: i_imem_resp_instr, pc: r_resp_pc};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_resp_keep),
        .i_push_data (w_push_data),
        .i_pop       (w_deq),
        .i_flush     (i_redirect),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Sequencing, PC tracking and outstanding-request bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= '0;
            r_resp_pc  <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            if (r_state == S_IDLE) r_state <= S_RUN;
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
                r_resp_pc  <= i_redirect_pc;
                r_inflight <= '0;
                // Everything still in flight becomes stale; a response landing now is one fewer
                r_drop     <= r_drop + r_inflight - CW'(w_resp_any);
            end else begin
                if (w_fire)      r_fetch_pc <= r_fetch_pc + 1'b1;
                if (w_resp_keep) r_resp_pc  <= r_resp_pc + 1'b1;
                r_inflight <= r_inflight + CW'(w_fire) - CW'(w_resp_keep);
                if (w_resp_drop) r_drop <= r_drop - 1'b1;
            end
        end
    end

    assign o_instr_valid = ~w_empty;
    assign o_instr       = w_empty ? '0 : w_head.instr;
    assign o_instr_pc    = w_empty ? '0 : w_head.pc;

    // Memory must never answer when no request is outstanding
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_resp_valid |-> ((r_inflight != '0) || (r_drop != '0)))
        else $error("imem response with no outstanding request");

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: memory model plus a queue-based reference
// of what the datapath should see.
module tb_instr_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [18:0] resp_instr;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic [18:0] instr;
    logic [11:0] instr_pc;
    logic        instr_ready;

    typedef struct {
        logic [11:0] maddr;
        logic [11:0] mpc;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        logic [18:0] instr;
        logic [11:0] pc;
    } ent_t;

    mreq_t       memq[$];
    ent_t        fq[$];
    logic [11:0] exp_fetch;
    bit          run;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          total;
    int          bad;

    instr_prefetch_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .o_imem_req_valid  (req_valid),
        .o_imem_req_addr   (req_addr),
        .i_imem_req_ready  (req_ready),
        .i_imem_resp_valid (resp_valid),
        .i_imem_resp_instr (resp_instr),
        .i_redirect        (redirect),
        .i_redirect_pc     (redirect_pc),
        .o_instr_valid     (instr_valid),
        .o_instr           (instr),
        .o_instr_pc        (instr_pc),
        .i_instr_ready     (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents
    function automatic logic [18:0] mem_data(input logic [11:0] a);
        return ({7'd0, a} * 19'd1237) ^ 19'h2B3C5;
    endfunction

    function automatic bit exp_req_valid();
        return run && !redirect && ((fq.size() + memq.size()) < DEPTH);
    endfunction

    // Apply one cycle of inputs mid-cycle; the memory answers from its queue
    task automatic drive(input bit rr, input bit ir, input bit rd, input logic [11:0] rpc);
        @(negedge clk);
        req_ready   = rr;
        instr_ready = ir;
        redirect    = rd;
        redirect_pc = rpc;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_instr = mem_data(memq[0].maddr);
        end else begin
            resp_valid = 1'b0;
            resp_instr = '0;
        end
        #1;
    endtask

    // Advance the reference by what happened this cycle
    task automatic commit();
        mreq_t m;
        int    lat;
        int    due;
        if (instr_valid && instr_ready && !redirect && fq.size() > 0) void'(fq.pop_front());
        if (resp_valid) begin
            m = memq.pop_front();
            if (!redirect && !m.stale) fq.push_back('{mem_data(m.mpc), m.mpc});
        end
        if (redirect) begin
            fq.delete();
            foreach (memq[i]) memq[i].stale = 1'b1;
            exp_fetch = redirect_pc;
        end
        if (req_valid && req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{req_addr, exp_fetch, due, 1'b0});
            exp_fetch = exp_fetch + 12'd1;
        end
        run = 1'b1;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_instr  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        memq.delete();
        fq.delete();
        run       = 1'b0;
        exp_fetch = '0;
        last_due  = 0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({req_valid, req_addr, instr_valid, instr, instr_pc} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%h_%b_%h_%h exp=all zero",
                     req_valid, req_addr, instr_valid, instr, instr_pc);
        end
        release_reset();
        total++;
        if (req_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_req got=%b exp=0", req_valid);
        end
        commit();
    endtask

    task automatic test_basic();
        int first_req;
        int first_val;
        first_req = -1;
        first_val = -1;
        lat_min   = 1;
        lat_max   = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            total++;
            if (req_valid !== exp_req_valid()) begin
                bad++;
                $display("FAIL basic_req_valid cyc=%0d got=%b exp=%b", cyc, req_valid, exp_req_valid());
            end
            if (req_valid === 1'b1) begin
                if (first_req < 0) first_req = cyc;
                total++;
                if (req_addr !== exp_fetch) begin
                    bad++;
                    $display("FAIL basic_req_addr got=%h exp=%h", req_addr, exp_fetch);
                end
            end
            if (instr_valid === 1'b1 && first_val < 0) first_val = cyc;
            total++;
            if (fq.size() > 0) begin
                if (instr_valid !== 1'b1 || instr_pc !== fq[0].pc || instr !== fq[0].instr) begin
                    bad++;
                    $display("FAIL basic_head got=%b/%h/%h exp=1/%h/%h",
                             instr_valid, instr_pc, instr, fq[0].pc, fq[0].instr);
                end
            end else if (instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_empty got=%b exp=0", instr_valid);
            end
            commit();
        end
        total++;
        if (first_req < 0 || first_val - first_req != 2) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=2", first_val - first_req);
        end
    endtask

    task automatic test_stall();
        int          nfire;
        int          ndeq;
        int          first_addr;
        logic [11:0] pcs [5];
        apply_reset();
        release_reset();
        commit();
        lat_min = 1;
        lat_max = 1;
        nfire   = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            if (req_valid === 1'b1) nfire++;
            commit();
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        total++;
        if (nfire != 4 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_credit got=%0d/%b exp=4/0", nfire, req_valid);
        end
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'h000) begin
            bad++;
            $display("FAIL stall_head got=%b/%h exp=1/000", instr_valid, instr_pc);
        end
        commit();
        ndeq       = 0;
        first_addr = -1;
        for (int i = 0; i < 30 && ndeq < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (req_valid === 1'b1 && first_addr < 0) first_addr = int'(req_addr);
            if (instr_valid === 1'b1) begin
                pcs[ndeq] = instr_pc;
                ndeq++;
            end
            commit();
        end
        total++;
        if (ndeq != 5) begin
            bad++;
            $display("FAIL stall_drain_count got=%0d exp=5", ndeq);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (pcs[k] !== 12'(k)) begin
                    bad++;
                    $display("FAIL stall_drain_pc idx=%0d got=%h exp=%h", k, pcs[k], 12'(k));
                end
            end
        end
        total++;
        if (first_addr != 4) begin
            bad++;
            $display("FAIL stall_refetch got=%0d exp=4", first_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        bit found;
        bit got;
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (memq.size() == 3) begin
                drive(1'b1, 1'b1, 1'b1, 12'h200);
                found = 1'b1;
                total++;
                if (req_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rdi_req_gated got=%b exp=0", req_valid);
                end
            end else begin
                drive(1'b1, 1'b1, 1'b0, '0);
            end
            commit();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rdi_setup got=no 3-deep window exp=3 in flight");
        end
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (instr_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (instr_pc !== 12'h200 || instr !== mem_data(12'h200)) begin
                    bad++;
                    $display("FAIL rdi_first got=%h/%h exp=200/%h", instr_pc, instr, mem_data(12'h200));
                end
            end
            commit();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rdi_timeout got=no instr exp=pc 200");
        end
    endtask

    task automatic test_redirect_coincident();
        bit found;
        bit got;
        lat_min = 1;
        lat_max = 1;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (fq.size() > 0 && memq.size() > 0 && memq[0].due <= cyc) begin
                drive(1'b1, 1'b1, 1'b1, 12'h0A0);
                found = 1'b1;
                total++;
                if (instr_valid !== 1'b1 || req_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rdc_cycle got=valid %b req %b exp=valid 1 req 0", instr_valid, req_valid);
                end
            end else begin
                drive(1'b1, 1'b1, 1'b0, '0);
            end
            commit();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rdc_setup got=no coincident window exp=one");
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        total++;
        if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 12'h0A0) begin
            bad++;
            $display("FAIL rdc_after got=%b/%b/%h exp=0/1/0a0", instr_valid, req_valid, req_addr);
        end
        commit();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (instr_valid === 1'b1) begin
                got = 1'b1;
                total++;
                if (instr_pc !== 12'h0A0) begin
                    bad++;
                    $display("FAIL rdc_first got=%h exp=0a0", instr_pc);
                end
            end
            commit();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rdc_timeout got=no instr exp=pc 0a0");
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_pcs [4];
        int          n;
        exp_pcs = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        lat_min = 1;
        lat_max = 2;
        drive(1'b1, 1'b1, 1'b1, 12'hFFE);
        commit();
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            if (instr_valid === 1'b1) begin
                total++;
                if (instr_pc !== exp_pcs[n] || instr !== mem_data(exp_pcs[n])) begin
                    bad++;
                    $display("FAIL wrap_pc idx=%0d got=%h exp=%h", n, instr_pc, exp_pcs[n]);
                end
                n++;
            end
            commit();
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=4", n);
        end
    endtask

    task automatic test_random();
        bit rr;
        bit ir;
        bit rd;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(3, 0) != 0);
            ir = ($urandom_range(2, 0) != 0);
            rd = ($urandom_range(31, 0) == 0);
            drive(rr, ir, rd, 12'($urandom));
            total++;
            if (req_valid !== exp_req_valid()) begin
                bad++;
                $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", cyc, req_valid, exp_req_valid());
            end
            if (req_valid === 1'b1) begin
                total++;
                if (req_addr !== exp_fetch) begin
                    bad++;
                    $display("FAIL rand_req_addr cyc=%0d got=%h exp=%h", cyc, req_addr, exp_fetch);
                end
            end
            total++;
            if (fq.size() > 0) begin
                if (instr_valid !== 1'b1 || instr_pc !== fq[0].pc || instr !== fq[0].instr) begin
                    bad++;
                    $display("FAIL rand_head cyc=%0d got=%b/%h/%h exp=1/%h/%h",
                             cyc, instr_valid, instr_pc, instr, fq[0].pc, fq[0].instr);
                end
            end else if (instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL rand_empty cyc=%0d got=%b exp=0", cyc, instr_valid);
            end
            commit();
        end
    endtask

    task automatic test_mid_reset();
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            commit();
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        total++;
        if (instr_valid !== 1'b1 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_full got=%b/%b exp=1/0", instr_valid, req_valid);
        end
        commit();
        apply_reset();
        total++;
        if ({req_valid, req_addr, instr_valid, instr, instr_pc} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b_%h_%b_%h_%h exp=all zero",
                     req_valid, req_addr, instr_valid, instr, instr_pc);
        end
        release_reset();
        commit();
        drive(1'b1, 1'b1, 1'b0, '0);
        total++;
        if (req_valid !== 1'b1 || req_addr !== 12'h000) begin
            bad++;
            $display("FAIL midrst_restart got=%b/%h exp=1/000", req_valid, req_addr);
        end
        commit();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0);
            commit();
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        last_due    = 0;
        lat_min     = 1;
        lat_max     = 1;
        run         = 1'b0;
        exp_fetch   = '0;
        rst_n       = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_instr  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Instruction fetch front end that sits directly upstream of the single-cycle 8-bit datapath. It issues sequential 12-bit fetch addresses to a variable-latency instruction memory and buffers returned 19-bit instructions, each tagged with its PC, in a small FIFO. It presents one instruction at a time to the datapath over a valid/ready handshake. Branch and jump redirects from the datapath flush the buffer, discard stale in-flight responses, and restart fetch at the target.

## Interface
- DEPTH, 4: FIFO entries and maximum outstanding requests; power of two, ≥2.
- PC_W, 12: fetch address width.
- INSTR_W, 19: instruction width.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  PC_W  fetch address (= fetch_pc).
- imem_req_ready  in  1  memory accepts request; fire = valid & ready.
- imem_resp_valid  in  1  one response per accepted request, strictly in order, ≥1 cycle after its request fires.
- imem_resp_instr  in  INSTR_W  returned instruction.
- redirect  in  1  datapath takes a branch or jump this cycle.
- redirect_pc  in  PC_W  new fetch target.
- instr_valid  out  1  FIFO head valid.
- instr  out  INSTR_W  head instruction.
- instr_pc  out  PC_W  address of head instruction.
- instr_ready  in  1  datapath consumes head; deq = valid & ready.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next kept response.
  - count: FIFO occupancy, 0..DEPTH.
  - inflight: kept requests awaiting a response.
  - drop: stale requests awaiting a response.
  - FSM S_IDLE / S_RUN.
- Reset: FSM = S_IDLE; fetch_pc = resp_pc = 0; count = inflight = drop = 0. Resulting outputs: imem_req_valid = 0, imem_req_addr = 0, instr_valid = 0, instr = 0, instr_pc = 0.
- S_IDLE → S_RUN unconditionally one cycle after reset release. No requests are issued in S_IDLE.
- imem_req_valid = S_RUN & !redirect & (count + inflight + drop < DEPTH). Because the credit check includes every outstanding request, every response always has a FIFO slot.
- On request fire: fetch_pc += 1, wrapping modulo 2^PC_W (4095 → 0); inflight += 1.
- On response with drop > 0: drop -= 1, and the data is discarded.
- On response with drop = 0: enqueue {imem_resp_instr, resp_pc}; resp_pc += 1 (wraps); inflight -= 1.
- On deq: count -= 1. Simultaneous enqueue and deq leave count unchanged.
- Redirect (highest priority):
  - FIFO is cleared (count = 0); any deq that cycle is ignored.
  - fetch_pc = resp_pc = redirect_pc.
  - drop = drop + inflight − (a response arrives this cycle ? 1 : 0); inflight = 0.
  - A response arriving in the redirect cycle is discarded.
  - No request fires in the redirect cycle, since req_valid is gated.
- imem_resp_valid with inflight = drop = 0 is a protocol error: ignore it, and an assertion must flag it.
- Counter widths are $clog2(DEPTH+1); arithmetic never over- or underflows under legal stimulus.

## Timing
- Reset deassert at edge E: S_RUN from E+1. The first request (addr 0) is valid in cycle E+1.
- Response in cycle N with FIFO empty: instr_valid = 1 in cycle N+1. There is no bypass, so minimum fetch-to-datapath latency is 2 cycles with a 1-cycle memory.
- Redirect in cycle N: instr_valid = 0 in N+1; the first request to redirect_pc is issued in N+1.
- Full throughput is 1 instruction per cycle when memory latency is 1 and DEPTH ≥ 2.
- Full FIFO with instr_ready = 0: requests stop once count + inflight + drop = DEPTH. The head is held stable.
- Reset assertion mid-operation clears all state immediately; in-flight responses arriving after reset release must not occur, since the memory shares the same reset.

## Structure
- fetch_pkg:
  - PC_W and INSTR_W localparams.
  - typedef struct packed {logic [INSTR_W-1:0] instr; logic [PC_W-1:0] pc;} fetch_entry_t.
  - typedef enum {S_IDLE, S_RUN} fetch_state_t.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH entries, push/pop/flush, and count out. The top level holds the FSM, credit counters and PC registers.

## Test plan
- Reset then constant 1-cycle memory with instr_ready = 1 → requests at addresses 0, 1, 2, …. instr_valid first appears 2 cycles after the first request. instr_pc runs 0, 1, 2, … at 1 per cycle.
- instr_ready = 0 with 1-cycle memory → exactly 4 requests are issued, count = 4, then imem_req_valid = 0. Raising ready drains PCs 0 to 3 and refetch resumes at 4.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x200 → the 3 old responses are discarded. The next instruction presented has instr_pc = 0x200.
- Redirect coincident with a response and a deq → that response is dropped. The FIFO is empty the next cycle, and no request fires during the redirect cycle.
- Redirect to 0xFFE, run 4 instructions → instr_pc sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Assert rst mid-stream with a full FIFO → all outputs are 0 immediately. After release, fetch restarts at address 0.
